// File: rtl/vga_frame_monitor.sv
// vga_frame_monitor: receive-side checker for a VGA stream. Rebuilds pixel
// coordinates from sync falls only, checks line and frame timing, tracks
// lock, and counts lit pixels in each good frame.
module vga_frame_monitor #(
    parameter int H_TOTAL  = 800,
    parameter int V_TOTAL  = 525,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_START  = 144,
    parameter int V_START  = 34
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_pix_stb,
    input  logic        i_hs,
    input  logic        i_vs,
    input  logic [3:0]  i_r,
    input  logic [3:0]  i_g,
    input  logic [3:0]  i_b,
    output logic [9:0]  o_x,
    output logic [8:0]  o_y,
    output logic        o_de,
    output logic        o_locked,
    output logic        o_frame_done,
    output logic [18:0] o_lit_cnt,
    output logic [15:0] o_frame_cnt,
    output logic        o_err,
    output logic [7:0]  o_err_cnt
);

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_ALIGN  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LINES = 10'(V_TOTAL);
    localparam logic [9:0] H_LO    = 10'(H_START);
    localparam logic [9:0] H_HI    = 10'(H_START + H_ACTIVE);
    localparam logic [9:0] V_LO    = 10'(V_START);
    localparam logic [9:0] V_HI    = 10'(V_START + V_ACTIVE);
    localparam logic [9:0] H_STUCK = 10'd1022;

    logic [1:0]  state_q, state_d;
    logic        hs_prev_q, hs_prev_d;
    logic        vs_prev_q, vs_prev_d;
    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic        vs_pend_q, vs_pend_d;
    logic        hs_seen_q, hs_seen_d;
    logic        checks_on_q, checks_on_d;
    logic [9:0]  line_cnt_q, line_cnt_d;
    logic [18:0] lit_acc_q, lit_acc_d;
    logic [9:0]  x_q, x_d;
    logic [8:0]  y_q, y_d;
    logic        de_q, de_d;
    logic        locked_q, locked_d;
    logic        frame_done_q, frame_done_d;
    logic [18:0] lit_cnt_q, lit_cnt_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        err_q, err_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    logic hs_fall, vs_fall, active;
    logic line_bad, frame_bad, stuck, viol, frame_ok;
    logic pixel_de;

    // Sync edge detection and the timing checks evaluated on this strobe.
    always_comb begin
        hs_fall   = i_pix_stb & hs_prev_q & ~i_hs;
        vs_fall   = i_pix_stb & vs_prev_q & ~i_vs;
        active    = (state_q != ST_SEARCH);
        line_bad  = active & checks_on_q & hs_seen_q & hs_fall & (h_cnt_q != H_LAST);
        frame_bad = active & checks_on_q & vs_fall & (line_cnt_q != V_LINES);
        stuck     = active & i_pix_stb & ~hs_fall & (h_cnt_q == H_STUCK);
        viol      = line_bad | frame_bad | stuck;
        frame_ok  = active & checks_on_q & vs_fall & ~viol;
    end

    // Lock state machine; a violation suspends checking until the next VS fall.
    always_comb begin
        state_d     = state_q;
        checks_on_d = checks_on_q;
        case (state_q)
            ST_SEARCH: begin
                if (vs_fall) begin
                    state_d     = ST_ALIGN;
                    checks_on_d = 1'b1;
                end
            end
            ST_ALIGN: begin
                if (stuck) begin
                    state_d     = ST_SEARCH;
                    checks_on_d = 1'b0;
                end else if (viol) begin
                    checks_on_d = 1'b0;
                end else if (vs_fall) begin
                    if (checks_on_q) state_d = ST_LOCKED;
                    else checks_on_d = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (stuck) begin
                    state_d     = ST_SEARCH;
                    checks_on_d = 1'b0;
                end else if (viol) begin
                    state_d     = ST_ALIGN;
                    checks_on_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_SEARCH;
                checks_on_d = 1'b0;
            end
        endcase
    end

    // Position counters: VS fall is handled before a coincident HS fall.
    always_comb begin
        hs_prev_d  = i_pix_stb ? i_hs : hs_prev_q;
        vs_prev_d  = i_pix_stb ? i_vs : vs_prev_q;
        h_cnt_d    = h_cnt_q;
        v_cnt_d    = v_cnt_q;
        vs_pend_d  = vs_pend_q;
        line_cnt_d = line_cnt_q;
        if (state_d == ST_SEARCH) begin
            h_cnt_d    = 10'd0;
            v_cnt_d    = 10'd0;
            vs_pend_d  = 1'b0;
            line_cnt_d = 10'd0;
        end else if (i_pix_stb) begin
            if (vs_fall) begin
                vs_pend_d  = 1'b1;
                line_cnt_d = 10'd0;
            end
            if (hs_fall) begin
                h_cnt_d = 10'd0;
                if (vs_pend_d) begin
                    v_cnt_d   = 10'd0;
                    vs_pend_d = 1'b0;
                end else begin
                    v_cnt_d = v_cnt_q + 10'd1;
                end
                if (line_cnt_d != 10'h3FF) line_cnt_d = line_cnt_d + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
    end

    // Tracks whether this state (or restarted check window) has seen its first HS fall.
    always_comb begin
        hs_seen_d = hs_seen_q | hs_fall;
        if (state_d == ST_SEARCH) begin
            hs_seen_d = 1'b0;
        end else if ((state_d != state_q) || (vs_fall && !checks_on_q)) begin
            hs_seen_d = hs_fall;
        end
    end

    // Visible-area decode and lit-pixel accumulation for the pixel on this strobe.
    always_comb begin
        pixel_de = (state_d != ST_SEARCH) &&
                   (h_cnt_d >= H_LO) && (h_cnt_d < H_HI) &&
                   (v_cnt_d >= V_LO) && (v_cnt_d < V_HI);
        de_d = i_pix_stb ? pixel_de : de_q;
        x_d  = x_q;
        y_d  = y_q;
        if (i_pix_stb && pixel_de) begin
            x_d = h_cnt_d - H_LO;
            y_d = 9'(v_cnt_d - V_LO);
        end
        lit_acc_d = lit_acc_q;
        if (vs_fall) begin
            lit_acc_d = 19'd0;
        end else if (i_pix_stb && pixel_de && ((i_r | i_g | i_b) != 4'd0)) begin
            lit_acc_d = lit_acc_q + 19'd1;
        end
    end

    // Status outputs: frame completion, error pulse and counters.
    always_comb begin
        locked_d     = (state_d == ST_LOCKED);
        frame_done_d = (state_q == ST_LOCKED) && frame_ok;
        lit_cnt_d    = frame_done_d ? lit_acc_q : lit_cnt_q;
        frame_cnt_d  = frame_done_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
        err_d        = viol;
        err_cnt_d    = (viol && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_SEARCH;
            hs_prev_q    <= 1'b0;
            vs_prev_q    <= 1'b0;
            h_cnt_q      <= 10'd0;
            v_cnt_q      <= 10'd0;
            vs_pend_q    <= 1'b0;
            hs_seen_q    <= 1'b0;
            checks_on_q  <= 1'b0;
            line_cnt_q   <= 10'd0;
            lit_acc_q    <= 19'd0;
            x_q          <= 10'd0;
            y_q          <= 9'd0;
            de_q         <= 1'b0;
            locked_q     <= 1'b0;
            frame_done_q <= 1'b0;
            lit_cnt_q    <= 19'd0;
            frame_cnt_q  <= 16'd0;
            err_q        <= 1'b0;
            err_cnt_q    <= 8'd0;
        end else begin
            state_q      <= state_d;
            hs_prev_q    <= hs_prev_d;
            vs_prev_q    <= vs_prev_d;
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            vs_pend_q    <= vs_pend_d;
            hs_seen_q    <= hs_seen_d;
            checks_on_q  <= checks_on_d;
            line_cnt_q   <= line_cnt_d;
            lit_acc_q    <= lit_acc_d;
            x_q          <= x_d;
            y_q          <= y_d;
            de_q         <= de_d;
            locked_q     <= locked_d;
            frame_done_q <= frame_done_d;
            lit_cnt_q    <= lit_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            err_q        <= err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign o_x          = x_q;
    assign o_y          = y_q;
    assign o_de         = de_q;
    assign o_locked     = locked_q;
    assign o_frame_done = frame_done_q;
    assign o_lit_cnt    = lit_cnt_q;
    assign o_frame_cnt  = frame_cnt_q;
    assign o_err        = err_q;
    assign o_err_cnt    = err_cnt_q;

endmodule
